// File: rtl/uart_rx_os_if.sv
// Host-side receive handshake of uart_rx_os: received word, valid/ack pair and error flags.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output overrun_err,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  overrun_err,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: synchronises rx, validates the start bit, samples mid-bit,
// checks parity/stop and hands the word to the host through a valid/ack handshake.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           rx,
    uart_rx_os_if.master   host,
    output logic           busy
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 rx_s_q;
    logic                 rx_s_prev_q;
    logic [CNT_W-1:0]     tcnt_q;
    logic [BIT_W-1:0]     bcnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 commit_q;
    logic                 fe_pend_q;
    logic                 pe_pend_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 oerr_q;
    logic                 busy_q;
    logic                 fall_d;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] word, input logic pbit);
        logic x;
        x = (^word) ^ pbit;
        case (PARITY)
            1:       return ~x;
            2:       return x;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_s_prev_q <= 1'b1;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            rx_s_prev_q <= rx_s_q;
        end
    end

    assign fall_d = rx_s_prev_q & ~rx_s_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            commit_q  <= 1'b0;
            fe_pend_q <= 1'b0;
            pe_pend_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            oerr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            commit_q <= 1'b0;

            // Commit takes priority over a simultaneous ack so new data is never lost.
            if (commit_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                ferr_q  <= fe_pend_q;
                perr_q  <= pe_pend_q;
                oerr_q  <= valid_q & ~host.rx_ack;
            end else if (valid_q && host.rx_ack) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (fall_d) begin
                        state_q   <= S_START;
                        busy_q    <= 1'b1;
                        tcnt_q    <= '0;
                        pe_pend_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tcnt_q == HALF_M1) begin
                            if (rx_s_q) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_DATA;
                                tcnt_q  <= '0;
                                bcnt_q  <= '0;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tcnt_q == FULL_M1) begin
                            tcnt_q  <= '0;
                            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            if (bcnt_q == BIT_LAST) begin
                                bcnt_q  <= '0;
                                state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (tcnt_q == FULL_M1) begin
                            tcnt_q    <= '0;
                            pe_pend_q <= parity_bad(shift_q, rx_s_q);
                            state_q   <= S_STOP;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit re-arms edge detection for back-to-back frames.
                    if (tick) begin
                        if (tcnt_q == FULL_M1) begin
                            tcnt_q    <= '0;
                            fe_pend_q <= ~rx_s_q;
                            commit_q  <= 1'b1;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign host.rx_data     = data_q;
    assign host.rx_valid    = valid_q;
    assign host.frame_err   = ferr_q;
    assign host.parity_err  = perr_q;
    assign host.overrun_err = oerr_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: one receiver without parity and one with even parity.
module tb_uart_rx_os;
    localparam int BT = 64;  // clk per bit: tick every 4 clk, 16 ticks per bit

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic rx0 = 1'b0;
    logic rx2 = 1'b1;
    logic busy0, busy2;
    int   tdiv = 0;
    int   total = 0;
    int   bad = 0;

    uart_rx_os_if #(.DATA_BITS(8)) if0 ();
    uart_rx_os_if #(.DATA_BITS(8)) if2 ();

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx0), .host(if0), .busy(busy0)
    );
    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx2), .host(if2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv = (tdiv + 1) % 4;
        tick = (tdiv == 0);
    end

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [2:0] fl;   // {frame_err, parity_err, overrun_err}
    } exp_t;

    exp_t sbq[$];
    logic       pv[2]   = '{1'b0, 1'b0};
    logic [7:0] pdat[2] = '{8'h00, 8'h00};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [7:0] dat, input logic [2:0] fl);
        exp_t e;
        if (v === 1'b1 && (pv[d] !== 1'b1 || dat !== pdat[d])) begin
            chk_eq("sb_pending", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk_eq("c_dut", d, e.dut);
                chk_eq("c_data", dat, e.data);
                chk_eq("c_flags", fl, e.fl);
            end
        end
        pv[d]   = v;
        pdat[d] = dat;
    endtask

    always @(negedge clk) begin
        mon(0, if0.rx_valid, if0.rx_data, {if0.frame_err, if0.parity_err, if0.overrun_err});
        mon(1, if2.rx_valid, if2.rx_data, {if2.frame_err, if2.parity_err, if2.overrun_err});
    end

    task automatic push(input int d, input logic [7:0] b, input logic [2:0] fl);
        exp_t e;
        e.dut = d; e.data = b; e.fl = fl;
        sbq.push_back(e);
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx0 = v; else rx2 = v;
    endtask

    task automatic send(input int d, input logic [7:0] b, input int par, input logic stop);
        set_rx(d, 1'b0);
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(d, b[i]);
            repeat (BT) @(negedge clk);
        end
        if (par >= 0) begin
            set_rx(d, par[0]);
            repeat (BT) @(negedge clk);
        end
        set_rx(d, stop);
        repeat (BT) @(negedge clk);
        set_rx(d, 1'b1);
    endtask

    task automatic ack(input int d);
        if (d == 0) if0.rx_ack = 1'b1; else if2.rx_ack = 1'b1;
        @(negedge clk);
        if0.rx_ack = 1'b0;
        if2.rx_ack = 1'b0;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        if0.rx_ack = 1'b0;
        if2.rx_ack = 1'b0;

        // reset with the line held low
        repeat (5) @(negedge clk);
        chk_eq("rst_data", if0.rx_data, 8'h00);
        chk_eq("rst_valid", if0.rx_valid, 0);
        chk_eq("rst_flags", {if0.frame_err, if0.parity_err, if0.overrun_err}, 3'b000);
        chk_eq("rst_busy", busy0, 0);
        rx0 = 1'b1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("post_rst_busy0", busy0, 0);
        chk_eq("post_rst_busy2", busy2, 0);

        // single frame then one-clk ack
        push(0, 8'hA5, 3'b000);
        send(0, 8'hA5, -1, 1'b1);
        repeat (16) @(negedge clk);
        chk_eq("a5_valid", if0.rx_valid, 1);
        ack(0);
        chk_eq("a5_ack_clears", if0.rx_valid, 0);

        // false start glitch of 3 ticks
        seen = 1'b0;
        rx0 = 1'b0;
        repeat (12) begin @(negedge clk); if (busy0) seen = 1'b1; end
        rx0 = 1'b1;
        repeat (80) begin @(negedge clk); if (busy0) seen = 1'b1; end
        chk_eq("fs_busy_seen", seen, 1);
        chk_eq("fs_busy_end", busy0, 0);
        chk_eq("fs_valid", if0.rx_valid, 0);

        // stop bit forced low
        push(0, 8'h3C, 3'b100);
        send(0, 8'h3C, -1, 1'b0);
        repeat (BT) @(negedge clk);
        chk_eq("fe_flag", if0.frame_err, 1);
        ack(0);
        chk_eq("fe_sticky", if0.frame_err, 1);

        // back-to-back with no ack
        push(0, 8'h11, 3'b000);
        push(0, 8'h22, 3'b001);
        send(0, 8'h11, -1, 1'b1);
        send(0, 8'h22, -1, 1'b1);
        repeat (32) @(negedge clk);
        chk_eq("ovr_data", if0.rx_data, 8'h22);
        chk_eq("ovr_flag", if0.overrun_err, 1);
        ack(0);
        chk_eq("ovr_ack_valid", if0.rx_valid, 0);
        chk_eq("ovr_sticky", if0.overrun_err, 1);

        // back-to-back with ack exactly in the commit cycle of the second frame
        push(0, 8'h11, 3'b000);
        push(0, 8'h22, 3'b000);
        fork
            begin
                send(0, 8'h11, -1, 1'b1);
                send(0, 8'h22, -1, 1'b1);
            end
            begin
                int   falls = 0;
                int   n = 0;
                logic pb = busy0;
                while (falls < 2 && n < 3000) begin
                    @(negedge clk);
                    n++;
                    if (pb && !busy0) falls++;
                    pb = busy0;
                end
                chk_eq("ack_window", falls, 2);
                if (falls == 2) begin
                    if0.rx_ack = 1'b1;
                    @(negedge clk);
                    if0.rx_ack = 1'b0;
                end
            end
        join
        repeat (32) @(negedge clk);
        chk_eq("cw_valid", if0.rx_valid, 1);
        chk_eq("cw_ovr", if0.overrun_err, 0);
        chk_eq("cw_data", if0.rx_data, 8'h22);
        ack(0);

        // even parity: 0x07 has three ones, so parity bit 0 is wrong
        push(1, 8'h07, 3'b010);
        send(1, 8'h07, 0, 1'b1);
        repeat (16) @(negedge clk);
        chk_eq("par_bad", if2.parity_err, 1);
        ack(1);
        push(1, 8'h07, 3'b000);
        send(1, 8'h07, 1, 1'b1);
        repeat (16) @(negedge clk);
        chk_eq("par_good", if2.parity_err, 0);
        ack(1);

        // reset in the middle of the 4th data bit of 0xFF
        rx0 = 1'b0;
        repeat (BT) @(negedge clk);
        rx0 = 1'b1;
        repeat (3 * BT + BT / 2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (BT / 2 + 5 * BT) @(negedge clk);
        chk_eq("mid_rst_valid", if0.rx_valid, 0);
        chk_eq("mid_rst_busy", busy0, 0);
        push(0, 8'h5A, 3'b000);
        send(0, 8'h5A, -1, 1'b1);
        repeat (16) @(negedge clk);
        chk_eq("after_rst_data", if0.rx_data, 8'h5A);
        chk_eq("after_rst_valid", if0.rx_valid, 1);

        repeat (BT) @(negedge clk);
        chk_eq("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver that consumes the oversampled tick from the baud generator (OVERSAMPLE = 16 instance).
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples each bit at mid-bit.
- Checks optional parity and the stop bit, then presents the received word to the host through a valid/ack handshake with error flags.
- Sits between the pad-side rx pin and the host/FIFO logic; it is the receive counterpart of the TX path.

Parameters:
- DATA_BITS, 8: data bits per frame, LSB first; legal range 5-9.
- OVERSAMPLE, 16: ticks per bit period; must be even and >= 8; must match the baud generator's OVERSAMPLE.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
- tick  input  1  oversample enable, one clk wide, at BAUD_RATE*OVERSAMPLE.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last received word.
- rx_valid  output  1  rx_data holds an unread word.
- rx_ack  input  1  host consumes the word; meaningful only while rx_valid = 1.
- frame_err  output  1  stop bit sampled low on the last frame.
- parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY = 0.
- overrun_err  output  1  a frame completed while rx_valid was still 1.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (rst = 0 at a clk edge): FSM goes to IDLE; tick counter and bit counter = 0; both synchroniser flops = 1; shift register = 0. Outputs: rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun_err = 0, busy = 0. A reset mid-frame aborts the frame with no output update.
- Synchroniser: 2 flops; rx_s is the second flop. A 1->0 edge is detected when the previous rx_s = 1 and the current rx_s = 0, giving 2-3 clk of input latency.
- All sampling and counting advances only on clk edges where tick = 1. Edge detection in IDLE is evaluated every clk.
- FSM states: IDLE, START, DATA, PARITY (skipped when PARITY = 0), STOP.
  - IDLE -> START: on a falling edge of rx_s; clear the tick counter.
  - START: count ticks. At the tick where count = OVERSAMPLE/2-1, sample rx_s.
    - If 1: false start, go to IDLE with no flags.
    - If 0: clear the counter, go to DATA.
  - DATA: on the tick where count = OVERSAMPLE-1, shift rx_s into the MSB of the shift register (LSB-first reception) and clear the counter. After DATA_BITS samples, go to PARITY or STOP.
  - PARITY: sample at count = OVERSAMPLE-1.
    - Error if (XOR of data bits XOR parity bit) is 0 for odd parity.
    - Error if the same expression is 1 for even parity.
  - STOP: sample at count = OVERSAMPLE-1 (mid stop bit), then go straight to IDLE. The FSM is re-armed half a bit early so a back-to-back start edge is detected.
- Frame commit happens on the clk after the stop sample:
  - rx_data <= word; rx_valid <= 1.
  - frame_err and parity_err <= the values for this frame.
  - overrun_err <= 1 if rx_valid was 1 and rx_ack was 0 in that cycle, else 0.
  - Frames with frame_err are still committed, so the host sees both the data and the flag.
- Handshake:
  - rx_valid stays high until a clk with rx_ack = 1; it then clears on the next edge.
  - rx_ack while rx_valid = 0 is ignored.
  - Commit and rx_ack in the same cycle: commit wins, rx_valid stays 1, overrun_err = 0, new data is presented.
  - Error flags are sticky until the next commit or reset; they are not cleared by rx_ack.
- Break (rx held low): START validates and DATA collects all zeros. STOP samples 0, so the frame commits with frame_err = 1 and rx_data = 0. The FSM then returns to IDLE and waits for rx_s to go high, since no falling edge is seen while the line stays low.
- busy = 1 in every state except IDLE.
- Counter widths: tick counter is $clog2(OVERSAMPLE) bits; bit counter is $clog2(DATA_BITS+1) bits. Neither wraps except through its explicit clear.

Test Plan:
- Reset behaviour: hold rst = 0 for 5 clk with rx = 0 -> all outputs 0, busy = 0; after rst = 1 and rx = 1, busy stays 0.
- Single frame (tick every 4 clk, OVERSAMPLE = 16, PARITY = 0): send 0xA5 -> one commit, rx_data = 0xA5, rx_valid = 1, all error flags 0. rx_ack for 1 clk -> rx_valid = 0 on the next edge.
- False start: 3-tick low glitch on rx -> busy pulses high, returns to IDLE, no commit, rx_valid stays 0.
- Errors:
  - Stop bit forced 0 on frame 0x3C -> rx_data = 0x3C, frame_err = 1.
  - PARITY = 2, send 0x07 with parity bit 0 -> parity_err = 1.
  - Resend with parity bit 1 -> parity_err = 0.
- Overrun and back-to-back: send 0x11 then 0x22 with no stop gap and no rx_ack -> rx_data = 0x22, overrun_err = 1. Repeat with rx_ack in the exact commit cycle of 0x22 -> rx_valid = 1, overrun_err = 0.
- Reset mid-frame: assert rst = 0 during the 4th data bit of 0xFF -> no commit; the next clean frame 0x5A is received correctly.
